z_stage: RTL

Z_STAGE -- requirements
Module: z_stage

---
 rtl/z_stage_pkg.sv | 32 +++
 rtl/z_stage_if.sv | 28 ++
 rtl/z_fifo.sv | 65 ++++++
 rtl/z_stage.sv | 98 +++++++++
 4 files changed

// File: rtl/z_stage_pkg.sv
// rtl/z_stage_pkg.sv - Opcode constants, drain FSM encoding, buffer entry type and beat-count helper
package z_stage_pkg;

  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SRL  = 4'b1011;
  localparam logic [3:0] OP_SHRA = 4'b1100;
  localparam logic [3:0] OP_ADD  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EMIT_LO = 2'd1,
    ST_EMIT_HI = 2'd2
  } z_state_e;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] z_high;
    logic [31:0] z_low;
  } z_entry_t;

  // MUL and DIV carry a meaningful high word; everything else, including unknown codes, is one beat.
  function automatic logic is_two_beat(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/z_stage_if.sv
// rtl/z_stage_if.sv - Result-in / write-back-out handshake bundle for z_stage
interface z_stage_if;

  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op_code;
  logic [31:0] z_low;
  logic [31:0] z_high;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_hi;
  logic        flag_zero;
  logic        flag_neg;
  logic        busy;

  modport master (
    output in_valid, op_code, z_low, z_high, out_ready,
    input  in_ready, out_valid, out_data, out_hi, flag_zero, flag_neg, busy
  );

  modport slave (
    input  in_valid, op_code, z_low, z_high, out_ready,
    output in_ready, out_valid, out_data, out_hi, flag_zero, flag_neg, busy
  );

endinterface

// File: rtl/z_fifo.sv
// rtl/z_fifo.sv - DEPTH-entry result buffer with occupancy count and full/empty
module z_fifo
  import z_stage_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          push_i,
  input  z_entry_t      wr_data_i,
  input  logic          pop_i,
  output z_entry_t      rd_data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  z_entry_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign push_ok   = push_i && !full_o;
  assign pop_ok    = pop_i && !empty_o;

  // Next pointers and count; DEPTH is a power of two so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock) begin
    if (!clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because count gates every read.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/z_stage.sv
// rtl/z_stage.sv - ALU result write-back stage; Z_STAGE_FLAGS_EN enables zero/negative flags
module z_stage
  import z_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic  clock,
  input logic  clear,
  z_stage_if.slave zif
);

  localparam int CW = $clog2(DEPTH) + 1;

  z_state_e      state_q, state_d;
  z_entry_t      wr_entry, head;
  logic [CW-1:0] count;
  logic          full, empty, push, pop, more;
  logic          out_valid, out_hi;
  logic [31:0]   out_data;

  assign wr_entry = {zif.op_code, zif.z_high, zif.z_low};
  assign push     = zif.in_valid && !full;
  // After popping the head, another entry is available if one was already queued or arrives now.
  assign more     = (count > CW'(1)) || push;

  z_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .clear     (clear),
    .push_i    (push),
    .wr_data_i (wr_entry),
    .pop_i     (pop),
    .rd_data_o (head),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty)
  );

  // Drain FSM state register.
  always_ff @(posedge clock) begin
    if (!clear) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Drain FSM next state, head pop and beat presentation.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    out_valid = 1'b0;
    out_hi    = 1'b0;
    out_data  = '0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) state_d = ST_EMIT_LO;
      end
      ST_EMIT_LO: begin
        out_valid = 1'b1;
        out_data  = head.z_low;
        if (zif.out_ready) begin
          if (is_two_beat(head.op)) begin
            state_d = ST_EMIT_HI;
          end else begin
            pop     = 1'b1;
            state_d = more ? ST_EMIT_LO : ST_IDLE;
          end
        end
      end
      ST_EMIT_HI: begin
        out_valid = 1'b1;
        out_hi    = 1'b1;
        out_data  = head.z_high;
        if (zif.out_ready) begin
          pop     = 1'b1;
          state_d = more ? ST_EMIT_LO : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign zif.in_ready  = !full;
  assign zif.out_valid = out_valid;
  assign zif.out_hi    = out_hi;
  assign zif.out_data  = out_data;
  assign zif.busy      = (count != '0) || (state_q != ST_IDLE);

`ifdef Z_STAGE_FLAGS_EN
  logic head_mul;
  assign head_mul      = (head.op == OP_MUL);
  // MUL flags describe the full 64-bit product; all other results use the low word only.
  assign zif.flag_zero = out_valid && (head_mul ? ((head.z_high == '0) && (head.z_low == '0))
                                                : (head.z_low == '0));
  assign zif.flag_neg  = out_valid && (head_mul ? head.z_high[31] : head.z_low[31]);
`else
  assign zif.flag_zero = 1'b0;
  assign zif.flag_neg  = 1'b0;
`endif

endmodule
